pattern_scan_controller: RTL
============================

// Module: pattern_scan_controller
// PURPOSE
//  Sequences a wildcard pattern matcher over a burst of bytes from a valid/ready stream.
//  Holds NUM_PAT programmable value/care-mask pairs, snapshotted at start.
//  Accumulates which patterns hit, and where the first hit occurred.
//  Sits between a byte source (DMA/UART front end) and a status/interrupt register bank.
// PARAMETERS
//  DW       8   data/pattern width in bits
//  NUM_PAT  3   number of pattern slots
//  LEN_W    8   burst-length / byte-index width
//  CNT_W    8   per-pattern hit counter width (used only with PSC_HIT_COUNT_EN)
// PORTS
//  clk          in   1              single clock, rising edge
//  rst          in   1              synchronous, active-high reset
//  start        in   1              begin burst; accepted only in IDLE
//  len          in   LEN_W          bytes in burst; sampled on accepted start
//  stop_on_hit  in   1              end burst at first hit; sampled on start
//  pat_val      in   NUM_PAT*DW     pattern values; slot k = [k*DW +: DW]
//  pat_care     in   NUM_PAT*DW     1 = bit compared, 0 = don't-care
//  in_data      in   DW             stream byte
//  in_valid     in   1              stream valid
//  in_ready     out  1              stream ready; high only in SCAN
//  busy         out  1              high in SCAN and DONE
//  done         out  1              one-cycle pulse at burst end
//  hit_vec      out  NUM_PAT        sticky OR of matches this burst
//  first_valid  out  1              at least one hit this burst
//  first_idx    out  LEN_W          beat index (0-based) of first hit
//  first_pat    out  NUM_PAT        all slots matching at first_idx
//  hit_cnt      out  NUM_PAT*CNT_W  per-slot hit counts; 0 without macro
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; index counter 0; snapshot registers 0.
//  Match rule: slot k hits when ((in_data ^ val_k) & care_k) == 0; all-zero care matches any byte.
//  FSM states:
//   IDLE -> SCAN  on start with len != 0: snapshot pat_val/pat_care/len/stop_on_hit; clear hit_vec, first_*, hit_cnt, index.
//   IDLE -> DONE  on start with len == 0: clear as above; no beats accepted.
//   SCAN: in_ready = 1; a beat is accepted when in_valid && in_ready.
//    Each accepted beat updates hit_vec/first_*/hit_cnt at that edge (visible next cycle) and increments index.
//   SCAN -> DONE  at the edge accepting beat len-1, or at any accepted beat with a hit when stop_on_hit = 1.
//   DONE: done = 1 and in_ready = 0 for exactly one cycle -> IDLE.
//  Results hold in IDLE until the next accepted start.
//  in_valid gaps stall the burst; index counts accepted beats only.
//  start outside IDLE is ignored. pat_*/len changes during a burst have no effect.
//  first_*: written only on the first hit beat of the burst; first_pat may hold several bits.
//  len = 2^LEN_W - 1 is the maximum burst; index never wraps within a burst.
//  rst mid-burst: immediate return to IDLE; outputs 0; no done pulse.
// CONFIGURATION
//  PSC_HIT_COUNT_EN defined: per-slot saturating CNT_W counters.
//   Each increments on an accepted beat that hits the slot; holds at all-ones; cleared on start.
//  PSC_HIT_COUNT_EN undefined: no counter registers; hit_cnt tied to 0; all else identical.
// STRUCTURE
//  pattern_scan_pkg: psc_state_e enum {IDLE, SCAN, DONE}; default localparams.
//  pattern_match_unit: combinational sub-module.
//   Inputs: data, NUM_PAT val/care pairs. Output: NUM_PAT hit vector.
//   Instanced once on in_data against the snapshot registers.
// TESTING (slot0 val 10000100 care 11001100; slot1 11000000/11001100; slot2 01000100/01010101)
//  1. len=5, stop=0, beats 10110100,11000011,01001010,10010111,11100010
//     -> done after 5th beat; hit_vec=011; first_idx=0; first_pat=001; hit_cnt={0,2,2} with macro.
//  2. len=0 start -> done pulse next cycle; in_ready never high; hit_vec=000; first_valid=0.
//  3. Same stream as 1, stop=1 -> only beat 0 accepted; done next cycle; first_idx=0; in_ready low after.
//  4. Test 1 with in_valid low on alternate cycles -> same results; index counts only accepted beats.
//  5. rst after 2 accepted beats -> next cycle: busy=0, hit_vec=000, no done.
//     New start with len=1, beat 11000011 -> hit_vec=010.
//  6. start pulsed and pat_val changed mid-burst of test 1 -> ignored; results identical to test 1.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// Shared types and default sizes for the pattern scan controller.
// Per-slot hit counters are built only when PSC_HIT_COUNT_EN is defined.
package pattern_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } psc_state_e;

   localparam int PSC_DW      = 8;
   localparam int PSC_NUM_PAT = 3;
   localparam int PSC_LEN_W   = 8;
   localparam int PSC_CNT_W   = 8;

endpackage

// File: rtl/pattern_match_unit.sv
// Combinational wildcard matcher: slot k hits when every cared bit of data equals val_k.
// A slot with an all-zero care mask matches any byte.
module pattern_match_unit
   import pattern_scan_pkg::*;
#(
   parameter int DW      = PSC_DW,
   parameter int NUM_PAT = PSC_NUM_PAT
) (
   input  logic [DW-1:0]         data_i,
   input  logic [NUM_PAT*DW-1:0] val_i,
   input  logic [NUM_PAT*DW-1:0] care_i,
   output logic [NUM_PAT-1:0]    hit_o
);

   always_comb begin
      hit_o = '0;
      for (int k = 0; k < NUM_PAT; k++) begin
         hit_o[k] = (((data_i ^ val_i[k*DW +: DW]) & care_i[k*DW +: DW]) == '0);
      end
   end

endmodule

// File: rtl/pattern_scan_controller.sv
// Runs a burst of stream bytes through the wildcard matcher and records which slots hit.
// Defining PSC_HIT_COUNT_EN adds saturating per-slot hit counters on hit_cnt.
//
// Stream handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in SCAN, and in_data is ignored on every other cycle.
module pattern_scan_controller
   import pattern_scan_pkg::*;
#(
   parameter int DW      = PSC_DW,
   parameter int NUM_PAT = PSC_NUM_PAT,
   parameter int LEN_W   = PSC_LEN_W,
   parameter int CNT_W   = PSC_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         len,
   input  logic                     stop_on_hit,
   input  logic [NUM_PAT*DW-1:0]    pat_val,
   input  logic [NUM_PAT*DW-1:0]    pat_care,
   input  logic [DW-1:0]            in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_PAT-1:0]       hit_vec,
   output logic                     first_valid,
   output logic [LEN_W-1:0]         first_idx,
   output logic [NUM_PAT-1:0]       first_pat,
   output logic [NUM_PAT*CNT_W-1:0] hit_cnt,
   output psc_state_e               dbg_state
);

   psc_state_e                state_q, state_d;
   logic [LEN_W-1:0]          idx_q, idx_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic                      stop_q, stop_d;
   logic [NUM_PAT*DW-1:0]     val_q, val_d;
   logic [NUM_PAT*DW-1:0]     care_q, care_d;
   logic [NUM_PAT-1:0]        hit_vec_q, hit_vec_d;
   logic                      first_valid_q, first_valid_d;
   logic [LEN_W-1:0]          first_idx_q, first_idx_d;
   logic [NUM_PAT-1:0]        first_pat_q, first_pat_d;
   logic [NUM_PAT-1:0]        beat_hit;
   logic                      start_ok;
   logic                      accept;

   pattern_match_unit #(
      .DW      (DW),
      .NUM_PAT (NUM_PAT)
   ) u_match (
      .data_i  (in_data),
      .val_i   (val_q),
      .care_i  (care_q),
      .hit_o   (beat_hit)
   );

   assign start_ok = start && (state_q == IDLE);
   assign accept   = in_valid && (state_q == SCAN);

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      len_d         = len_q;
      stop_d        = stop_q;
      val_d         = val_q;
      care_d        = care_q;
      hit_vec_d     = hit_vec_q;
      first_valid_d = first_valid_q;
      first_idx_d   = first_idx_q;
      first_pat_d   = first_pat_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d         = len;
               stop_d        = stop_on_hit;
               val_d         = pat_val;
               care_d        = pat_care;
               idx_d         = '0;
               hit_vec_d     = '0;
               first_valid_d = 1'b0;
               first_idx_d   = '0;
               first_pat_d   = '0;
               state_d       = (len == '0) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (in_valid) begin
               idx_d     = idx_q + LEN_W'(1);
               hit_vec_d = hit_vec_q | beat_hit;
               if ((beat_hit != '0) && !first_valid_q) begin
                  first_valid_d = 1'b1;
                  first_idx_d   = idx_q;
                  first_pat_d   = beat_hit;
               end
               // The last beat is detected by index so the counter never has to wrap.
               if ((idx_q == len_q - LEN_W'(1)) || (stop_q && (beat_hit != '0))) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         len_q         <= '0;
         stop_q        <= 1'b0;
         val_q         <= '0;
         care_q        <= '0;
         hit_vec_q     <= '0;
         first_valid_q <= 1'b0;
         first_idx_q   <= '0;
         first_pat_q   <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         len_q         <= len_d;
         stop_q        <= stop_d;
         val_q         <= val_d;
         care_q        <= care_d;
         hit_vec_q     <= hit_vec_d;
         first_valid_q <= first_valid_d;
         first_idx_q   <= first_idx_d;
         first_pat_q   <= first_pat_d;
      end
   end

`ifdef PSC_HIT_COUNT_EN
   logic [CNT_W-1:0] cnt_q [NUM_PAT];
   logic [CNT_W-1:0] cnt_d [NUM_PAT];

   always_comb begin
      for (int k = 0; k < NUM_PAT; k++) begin
         cnt_d[k] = cnt_q[k];
         if (start_ok) begin
            cnt_d[k] = '0;
         end else if (accept && beat_hit[k] && (cnt_q[k] != '1)) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_PAT; k++) begin
         if (rst) cnt_q[k] <= '0;
         else     cnt_q[k] <= cnt_d[k];
      end
   end

   for (genvar g = 0; g < NUM_PAT; g++) begin : g_cnt_out
      assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`else
   logic unused_cnt;
   assign unused_cnt = start_ok ^ accept;
   assign hit_cnt    = '0;
`endif

   assign in_ready    = (state_q == SCAN);
   assign busy        = (state_q == SCAN) || (state_q == DONE);
   assign done        = (state_q == DONE);
   assign hit_vec     = hit_vec_q;
   assign first_valid = first_valid_q;
   assign first_idx   = first_idx_q;
   assign first_pat   = first_pat_q;
   assign dbg_state   = state_q;

endmodule
